// File: rtl/fp_sub_arbiter.sv
// Round-robin front end sharing one external combinational FP32 subtractor among NUM_REQ requesters.
// Latency: grant at t -> resp_valid at t+2; one op in flight; optional stats under FP_SUB_ARB_STATS_EN.
// Backpressure: resp_valid/result/tag held until resp_ready; no new grant is issued until then.
module fp_sub_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int TAG_W   = $clog2(NUM_REQ)
) (
    input  logic                   CLK,
    input  logic                   nRST,
    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [NUM_REQ*32-1:0]  req_data1,
    input  logic [NUM_REQ*32-1:0]  req_data2,
    output logic [NUM_REQ-1:0]     req_ready,
    output logic [31:0]            sub_data1,
    output logic [31:0]            sub_data2,
    input  logic [31:0]            sub_result,
    output logic                   resp_valid,
    input  logic                   resp_ready,
    output logic [31:0]            resp_result,
    output logic [TAG_W-1:0]       resp_tag,
    output logic                   busy
`ifdef FP_SUB_ARB_STATS_EN
    ,
    output logic [15:0]            op_count,
    output logic [NUM_REQ-1:0]     last_grant_vec
`endif
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [TAG_W-1:0]       r_rr_ptr;
    logic [TAG_W-1:0]       r_tag;
    logic [31:0]            r_sub_data1;
    logic [31:0]            r_sub_data2;
    logic                   r_resp_valid;
    logic [31:0]            r_resp_result;
    logic [TAG_W-1:0]       r_resp_tag;

    logic [2*NUM_REQ-1:0]   w_dbl;
    logic [NUM_REQ-1:0]     w_rot;
    logic                   w_found;
    logic [TAG_W-1:0]       w_idx;
    logic [NUM_REQ-1:0]     w_grant;
    logic                   w_hs_req;
    logic                   w_hs_resp;

    function automatic logic [TAG_W-1:0] idx_add(input logic [TAG_W-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= NUM_REQ) s = s - NUM_REQ;
        return TAG_W'(s);
    endfunction

    // Rotate the request vector so bit 0 is the current priority holder.
    assign w_dbl = {req_valid, req_valid} >> r_rr_ptr;
    assign w_rot = w_dbl[NUM_REQ-1:0];

    // Descending scan: the lowest rotated position wins because it is written last.
    always_comb begin
        w_found = 1'b0;
        w_idx   = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (w_rot[k]) begin
                w_found = 1'b1;
                w_idx   = idx_add(r_rr_ptr, k);
            end
        end
    end

    assign w_grant   = w_found ? (NUM_REQ'(1) << w_idx) : '0;
    assign w_hs_req  = (r_state == S_IDLE) && w_found;
    assign w_hs_resp = (r_state == S_RESP) && resp_ready;

    // Gated with nRST so a held request never sees a grant while reset is asserted.
    assign req_ready = ((r_state == S_IDLE) && nRST) ? w_grant : '0;
    assign busy      = (r_state != S_IDLE);

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_found) w_state_nxt = S_EXEC;
            S_EXEC:  w_state_nxt = S_RESP;
            S_RESP:  if (resp_ready) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_rr_ptr      <= '0;
            r_tag         <= '0;
            r_sub_data1   <= '0;
            r_sub_data2   <= '0;
            r_resp_valid  <= 1'b0;
            r_resp_result <= '0;
            r_resp_tag    <= '0;
        end else begin
            if (w_hs_req) begin
                r_sub_data1 <= req_data1[32*w_idx +: 32];
                r_sub_data2 <= req_data2[32*w_idx +: 32];
                r_tag       <= w_idx;
                r_rr_ptr    <= idx_add(w_idx, 1);
            end
            if (r_state == S_EXEC) begin
                r_resp_result <= sub_result;
                r_resp_tag    <= r_tag;
                r_resp_valid  <= 1'b1;
            end else if (w_hs_resp) begin
                r_resp_valid  <= 1'b0;
            end
        end
    end

    assign sub_data1   = r_sub_data1;
    assign sub_data2   = r_sub_data2;
    assign resp_valid  = r_resp_valid;
    assign resp_result = r_resp_result;
    assign resp_tag    = r_resp_tag;

`ifdef FP_SUB_ARB_STATS_EN
    logic [15:0]        r_op_count;
    logic [NUM_REQ-1:0] r_last_grant;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_op_count   <= '0;
            r_last_grant <= '0;
        end else begin
            if (w_hs_resp && (r_op_count != 16'hFFFF)) r_op_count <= r_op_count + 16'd1;
            if (w_hs_req) r_last_grant <= w_grant;
        end
    end

    assign op_count       = r_op_count;
    assign last_grant_vec = r_last_grant;
`endif

endmodule

// File: tb/tb_fp_sub_arbiter.sv
// Directed + random bench for fp_sub_arbiter with a transaction-level reference model.
// Stub subtractor computes a real FP32 difference of sub_data1 - sub_data2.
module tb_fp_sub_arbiter;

    localparam int NUM_REQ = 4;
    localparam int TAG_W   = 2;

    logic                  CLK;
    logic                  nRST;
    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ*32-1:0] req_data1;
    logic [NUM_REQ*32-1:0] req_data2;
    logic [NUM_REQ-1:0]    req_ready;
    logic [31:0]           sub_data1;
    logic [31:0]           sub_data2;
    logic [31:0]           sub_result;
    logic                  resp_valid;
    logic                  resp_ready;
    logic [31:0]           resp_result;
    logic [TAG_W-1:0]      resp_tag;
    logic                  busy;
`ifdef FP_SUB_ARB_STATS_EN
    logic [15:0]           op_count;
    logic [NUM_REQ-1:0]    last_grant_vec;
`endif

    fp_sub_arbiter #(.NUM_REQ(NUM_REQ), .TAG_W(TAG_W)) dut (
        .CLK(CLK), .nRST(nRST),
        .req_valid(req_valid), .req_data1(req_data1), .req_data2(req_data2),
        .req_ready(req_ready),
        .sub_data1(sub_data1), .sub_data2(sub_data2), .sub_result(sub_result),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_result(resp_result), .resp_tag(resp_tag), .busy(busy)
`ifdef FP_SUB_ARB_STATS_EN
        , .op_count(op_count), .last_grant_vec(last_grant_vec)
`endif
    );

    function automatic logic [31:0] fsub(input logic [31:0] a, input logic [31:0] b);
        return $shortrealtobits($bitstoshortreal(a) - $bitstoshortreal(b));
    endfunction

    assign sub_result = fsub(sub_data1, sub_data2);

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    int errors = 0;
    int checks = 0;

    // Reference model: one outstanding transaction and the priority pointer.
    int          m_ptr;
    bit          m_inflight;
    int          m_age;
    int          m_tag;
    logic [31:0] m_d1, m_d2, m_res;
    int          m_cnt;
    logic [3:0]  m_last;
    int          m_log[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] rand_fp();
        case ($urandom_range(0, 9))
            0:       return 32'h7F80_0000;
            1:       return 32'hFF80_0000;
            2:       return 32'h8000_0000;
            3:       return 32'h7FC0_0000;
            default: return $urandom();
        endcase
    endfunction

    task automatic model_reset();
        m_ptr = 0; m_inflight = 0; m_age = 0; m_cnt = 0; m_last = '0;
    endtask

    task automatic do_reset(input logic [NUM_REQ-1:0] vld);
        @(negedge CLK);
        nRST = 1'b0;
        req_valid = vld;
        resp_ready = 1'b1;
        #1;
        chk("rst_req_ready", 32'(req_ready), 32'h0);
        chk("rst_resp_valid", 32'(resp_valid), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_sub_data1", sub_data1, 32'h0);
        chk("rst_sub_data2", sub_data2, 32'h0);
        chk("rst_resp_result", resp_result, 32'h0);
        chk("rst_resp_tag", 32'(resp_tag), 32'h0);
`ifdef FP_SUB_ARB_STATS_EN
        chk("rst_op_count", 32'(op_count), 32'h0);
        chk("rst_last_grant", 32'(last_grant_vec), 32'h0);
`endif
        repeat (2) @(negedge CLK);
        req_valid = '0;
        nRST = 1'b1;
        model_reset();
    endtask

    // One cycle: drive inputs, check outputs against the model, advance the model across the edge.
    task automatic step(input logic [NUM_REQ-1:0] vld, input logic rr,
                        input bit fix, input logic [31:0] f1, input logic [31:0] f2);
        int g;
        logic [NUM_REQ-1:0] exp_rdy;
        @(negedge CLK);
        req_valid  = vld;
        resp_ready = rr;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_data1[32*i +: 32] = fix ? f1 : rand_fp();
            req_data2[32*i +: 32] = fix ? f2 : rand_fp();
        end
        #1;
        g = -1;
        if (!m_inflight)
            for (int k = 0; k < NUM_REQ; k++)
                if (g < 0 && vld[(m_ptr + k) % NUM_REQ]) g = (m_ptr + k) % NUM_REQ;
        exp_rdy = (g >= 0) ? (NUM_REQ'(1) << g) : '0;
        chk("req_ready", 32'(req_ready), 32'(exp_rdy));
        chk("busy", 32'(busy), 32'(m_inflight));
        chk("resp_valid", 32'(resp_valid), 32'(m_inflight && m_age >= 1));
        if (m_inflight && m_age == 0) begin
            chk("sub_data1", sub_data1, m_d1);
            chk("sub_data2", sub_data2, m_d2);
        end
        if (m_inflight && m_age >= 1) begin
            chk("resp_tag", 32'(resp_tag), 32'(m_tag));
            chk("resp_result", resp_result, m_res);
        end
`ifdef FP_SUB_ARB_STATS_EN
        chk("op_count", 32'(op_count), 32'(m_cnt));
        chk("last_grant_vec", 32'(last_grant_vec), 32'(m_last));
`endif
        if (g >= 0) begin
            m_inflight = 1; m_age = 0; m_tag = g;
            m_d1  = req_data1[32*g +: 32];
            m_d2  = req_data2[32*g +: 32];
            m_res = fsub(m_d1, m_d2);
            m_ptr = (g + 1) % NUM_REQ;
            m_last = 4'(exp_rdy);
            m_log.push_back(g);
        end else if (m_inflight) begin
            if (m_age >= 1 && rr) begin
                m_inflight = 0;
                if (m_cnt < 65535) m_cnt++;
            end else begin
                m_age = 1;
            end
        end
    endtask

    initial begin
        logic [31:0] held_res;
        logic [31:0] held_tag;
        nRST = 1'b1; req_valid = '0; resp_ready = 1'b1; req_data1 = '0; req_data2 = '0;
        model_reset();

        // Reset with all requesters pending; first grant afterwards goes to requester 0
        do_reset(4'b1111);
        m_log.delete();
        step(4'b1111, 1'b1, 0, 0, 0);
        chk("first_grant", 32'(m_log.size() > 0 ? m_log[0] : -1), 32'd0);
        repeat (3) step(4'b0000, 1'b1, 0, 0, 0);

        // Single op with known operands
        do_reset(4'b0000);
        step(4'b0001, 1'b1, 1, 32'h42C8_6666, 32'h42B5_0000);
        step(4'b0000, 1'b1, 0, 0, 0);
        step(4'b0000, 1'b1, 0, 0, 0);
        chk("single_result", resp_result, fsub(32'h42C8_6666, 32'h42B5_0000));
        step(4'b0000, 1'b1, 0, 0, 0);

        // Round-robin order with every requester pending
        do_reset(4'b0000);
        m_log.delete();
        repeat (15) step(4'b1111, 1'b1, 0, 0, 0);
        chk("rr_count", 32'(m_log.size()), 32'd5);
        chk("rr_0", 32'(m_log[0]), 32'd0);
        chk("rr_1", 32'(m_log[1]), 32'd1);
        chk("rr_2", 32'(m_log[2]), 32'd2);
        chk("rr_3", 32'(m_log[3]), 32'd3);
        chk("rr_4", 32'(m_log[4]), 32'd0);

        // Backpressure: result held, no grants while waiting
        m_log.delete();
        step(4'b1111, 1'b1, 0, 0, 0);
        step(4'b1111, 1'b1, 0, 0, 0);
        step(4'b1111, 1'b0, 0, 0, 0);
        held_res = resp_result;
        held_tag = 32'(resp_tag);
        repeat (4) step(4'b1111, 1'b0, 0, 0, 0);
        chk("bp_result_stable", resp_result, held_res);
        chk("bp_tag_stable", 32'(resp_tag), held_tag);
        chk("bp_no_grant", 32'(m_log.size()), 32'd1);
        step(4'b1111, 1'b1, 0, 0, 0);
        step(4'b1111, 1'b1, 0, 0, 0);
        chk("bp_next_grant", 32'(m_log[1]), 32'd2);
        step(4'b0000, 1'b1, 0, 0, 0);
        step(4'b0000, 1'b1, 0, 0, 0);

        // Wrap/skip: pointer at 3, only requester 1 pending
        do_reset(4'b0000);
        m_log.delete();
        step(4'b0100, 1'b1, 0, 0, 0);
        repeat (2) step(4'b0000, 1'b1, 0, 0, 0);
        step(4'b0010, 1'b1, 0, 0, 0);
        chk("wrap_grant", 32'(m_log[1]), 32'd1);
        repeat (2) step(4'b0000, 1'b1, 0, 0, 0);
        step(4'b1111, 1'b1, 0, 0, 0);
        chk("wrap_ptr_after", 32'(m_log[2]), 32'd2);
        repeat (2) step(4'b0000, 1'b1, 0, 0, 0);

        // Reset during EXEC discards the operation
        do_reset(4'b0000);
        step(4'b1111, 1'b1, 0, 0, 0);
        do_reset(4'b1111);
        repeat (4) step(4'b0000, 1'b1, 0, 0, 0);

        // Random traffic
        do_reset(4'b0000);
        for (int n = 0; n < 400; n++)
            step(4'($urandom()), ($urandom_range(0, 3) != 0), 0, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
